mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the core's req/gnt/rvalid memory bus.
- Sits directly downstream of the execute-stage load/store unit (master 0, data) and the instruction fetch unit (master 1), in front of the shared memory/bus port.
- Tracks outstanding transactions in order and routes each slave rvalid/rdata back to the master that issued the request.
- Prevents fetch starvation under sustained data traffic.

---
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master (m0 data, m1 fetch) to one-slave req/gnt/rvalid arbiter with in-order response routing.
// Latency: grant and response routing are combinational (0 cycles); selection is registered only while locked.
// Backpressure: s_gnt_i stall holds the selected request stable; new grants stop once OUTSTANDING are in flight.
module mem_bus_arbiter #(
   parameter int OUTSTANDING  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             m0_req_i,
   input  logic [31:0]                      m0_addr_i,
   input  logic                             m0_we_i,
   input  logic [3:0]                       m0_be_i,
   input  logic [31:0]                      m0_wdata_i,
   output logic                             m0_gnt_o,
   output logic                             m0_rvalid_o,
   output logic [31:0]                      m0_rdata_o,
   input  logic                             m1_req_i,
   input  logic [31:0]                      m1_addr_i,
   input  logic                             m1_we_i,
   input  logic [3:0]                       m1_be_i,
   input  logic [31:0]                      m1_wdata_i,
   output logic                             m1_gnt_o,
   output logic                             m1_rvalid_o,
   output logic [31:0]                      m1_rdata_o,
   output logic                             s_req_o,
   output logic [31:0]                      s_addr_o,
   output logic                             s_we_o,
   output logic [3:0]                       s_be_o,
   output logic [31:0]                      s_wdata_o,
   input  logic                             s_gnt_i,
   input  logic                             s_rvalid_i,
   input  logic [31:0]                      s_rdata_i,
   output logic [$clog2(OUTSTANDING+1)-1:0] outstanding_o,
   output logic                             err_rvalid_o
);
   localparam int CW = $clog2(OUTSTANDING+1);
   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT+1) : 1;

   typedef enum logic {SEL_M0 = 1'b0, SEL_M1 = 1'b1} sel_e;
   typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_e;

   state_e              state_q, state_d;
   sel_e                sel, sel_q;
   logic [(1<<PW)-1:0]  id_fifo;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;
   logic [SW-1:0]       starve_cnt;
   logic                err_q;
   logic                sel_req, can_accept, grant, pop, empty, head, starve_hit;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUTSTANDING-1)) ? '0 : p + PW'(1);
   endfunction

   assign empty      = (count == '0);
   assign head       = id_fifo[rd_ptr];
   assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT));

   always_comb begin
      sel = SEL_M0;
      if (state_q == ST_LOCK)       sel = sel_q;
      else if (starve_hit && m1_req_i) sel = SEL_M1;
      else if (m0_req_i)            sel = SEL_M0;
      else if (m1_req_i)            sel = SEL_M1;
   end

   // A response retiring this cycle frees a slot, so a full tracker can still accept.
   assign sel_req    = (sel == SEL_M1) ? m1_req_i : m0_req_i;
   assign can_accept = (count < CW'(OUTSTANDING)) || s_rvalid_i;
   assign s_req_o    = sel_req && can_accept;
   assign grant      = s_req_o && s_gnt_i;
   assign m0_gnt_o   = grant && (sel == SEL_M0);
   assign m1_gnt_o   = grant && (sel == SEL_M1);

   always_comb begin
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
      if (s_req_o) begin
         s_addr_o  = (sel == SEL_M1) ? m1_addr_i  : m0_addr_i;
         s_we_o    = (sel == SEL_M1) ? m1_we_i    : m0_we_i;
         s_be_o    = (sel == SEL_M1) ? m1_be_i    : m0_be_i;
         s_wdata_o = (sel == SEL_M1) ? m1_wdata_i : m0_wdata_i;
      end
   end

   // Lock releases on grant, or if the locked master abandons its request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_ARB:  if (s_req_o && !s_gnt_i) state_d = ST_LOCK;
         ST_LOCK: if (grant || !sel_req)   state_d = ST_ARB;
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ARB;
         sel_q   <= SEL_M0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_ARB) sel_q <= sel;
      end
   end

   assign pop = s_rvalid_i && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_fifo <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (grant) begin
            id_fifo[wr_ptr] <= (sel == SEL_M1);
            wr_ptr          <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (grant && !pop)      count <= count + CW'(1);
         else if (pop && !grant) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         err_q      <= 1'b0;
      end else begin
         if (STARVE_LIMIT == 0 || !m1_req_i || m1_gnt_o) starve_cnt <= '0;
         else if (!starve_hit)                           starve_cnt <= starve_cnt + SW'(1);
         if (s_rvalid_i && empty) err_q <= 1'b1;
      end
   end

   assign m0_rvalid_o   = pop && !head;
   assign m1_rvalid_o   = pop && head;
   assign m0_rdata_o    = m0_rvalid_o ? s_rdata_i : '0;
   assign m1_rdata_o    = m1_rvalid_o ? s_rdata_i : '0;
   assign outstanding_o = count;
   assign err_rvalid_o  = err_q;
endmodule
